// File: rtl/psw_ccr_pkg.sv
// Shared CPU constants for the processor status word block:
// PSW bit positions, PSW load modes, trace states and the trace vector.
package psw_ccr_pkg;

    localparam int PSW_C       = 0;
    localparam int PSW_V       = 1;
    localparam int PSW_Z       = 2;
    localparam int PSW_N       = 3;
    localparam int PSW_T       = 4;
    localparam int PSW_PRI_LSB = 5;
    localparam int PSW_PRI_MSB = 7;

    localparam logic [7:0] TRACE_VEC = 8'o14;

    typedef enum logic [1:0] {
        PSW_RTI  = 2'b00,
        PSW_RTT  = 2'b01,
        PSW_MTPS = 2'b10,
        PSW_NOP  = 2'b11
    } psw_mode_e;

    typedef enum logic [1:0] {
        TR_IDLE  = 2'b00,
        TR_ARMED = 2'b01,
        TR_PEND  = 2'b10
    } trace_state_e;

endpackage

// File: rtl/psw_ccr_trace_fsm.sv
// T-bit trace sequencer: arms on an instruction start with T set,
// requests the trap when that instruction ends, clears on trap_ack.
module psw_ccr_trace_fsm
    import psw_ccr_pkg::*;
#(
    parameter bit TRACE_EN = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic ce,
    input  logic t_bit,
    input  logic rtt_load,
    input  logic instr_start,
    input  logic instr_end,
    input  logic trap_ack,
    output logic trace_req
);

    trace_state_e state_q;
    trace_state_e state_d;
    logic         inhibit_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= TR_IDLE;
            inhibit_q <= 1'b0;
        end else if (ce) begin
            state_q <= state_d;
            // RTT suppresses tracing of the instruction that follows it
            if (rtt_load)
                inhibit_q <= 1'b1;
            else if (instr_start)
                inhibit_q <= 1'b0;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            TR_IDLE:
                if (instr_start && t_bit && !inhibit_q)
                    state_d = TR_ARMED;
            TR_ARMED:
                if (instr_end)
                    state_d = TR_PEND;
            TR_PEND:
                if (trap_ack)
                    state_d = TR_IDLE;
            default:
                state_d = TR_IDLE;
        endcase
        if (!TRACE_EN)
            state_d = TR_IDLE;
    end

    always_comb begin
        trace_req = TRACE_EN && (state_q == TR_PEND);
    end

endmodule

// File: rtl/psw_ccr.sv
// PSW / condition-code register behind the ALU: flag commit,
// CLx/SEx, PSW loads, result latch, trace and interrupt requests.
module psw_ccr
    import psw_ccr_pkg::*;
#(
    parameter logic [15:0] PSW_RESET = 16'h00E0,
    parameter bit          TRACE_EN  = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ce,
    input  logic        alu_we,
    input  logic [3:0]  alu_flags,
    input  logic [3:0]  alu_ccmask,
    input  logic [15:0] alu_result,
    input  logic        cc_we,
    input  logic        cc_set,
    input  logic [3:0]  cc_bits,
    input  logic        psw_we,
    input  logic [1:0]  psw_mode,
    input  logic [15:0] psw_din,
    input  logic        instr_start,
    input  logic        instr_end,
    input  logic        trap_ack,
    input  logic        irq_valid,
    input  logic [2:0]  irq_pri,
    output logic [15:0] psw,
    output logic        ci,
    output logic        ni,
    output logic [15:0] result_q,
    output logic        trace_req,
    output logic        irq_pend
);

    logic [7:0]  psw_q;
    logic [7:0]  psw_d;
    logic [15:0] result_d;
    logic        rtt_load;
    logic [2:0]  pri;
    logic        unused_din;

    assign unused_din = ^psw_din[15:8];
    assign pri        = psw_q[PSW_PRI_MSB:PSW_PRI_LSB];
    assign rtt_load   = psw_we && (psw_mode_e'(psw_mode) == PSW_RTT);

    // One writer per cycle; a losing strobe drops flags and result alike
    always_comb begin
        psw_d    = psw_q;
        result_d = result_q;
        if (psw_we) begin
            unique case (psw_mode_e'(psw_mode))
                PSW_RTI, PSW_RTT: psw_d = psw_din[7:0];
                PSW_MTPS: psw_d = {psw_din[7:5], psw_q[PSW_T], psw_din[3:0]};
                default: psw_d = psw_q;
            endcase
        end else if (cc_we) begin
            psw_d[3:0] = cc_set ? (psw_q[3:0] | cc_bits)
                                : (psw_q[3:0] & ~cc_bits);
        end else if (alu_we) begin
            psw_d[3:0] = (psw_q[3:0] & ~alu_ccmask) | (alu_flags & alu_ccmask);
            result_d   = alu_result;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            psw_q    <= PSW_RESET[7:0];
            result_q <= 16'h0000;
            irq_pend <= 1'b0;
        end else if (ce) begin
            psw_q    <= psw_d;
            result_q <= result_d;
            irq_pend <= irq_valid && (irq_pri > pri);
        end
    end

    assign psw = {8'h00, psw_q};
    assign ci  = psw_q[PSW_C];
    assign ni  = psw_q[PSW_N];

    psw_ccr_trace_fsm #(
        .TRACE_EN (TRACE_EN)
    ) u_trace_fsm (
        .clk         (clk),
        .reset       (reset),
        .ce          (ce),
        .t_bit       (psw_q[PSW_T]),
        .rtt_load    (rtt_load),
        .instr_start (instr_start),
        .instr_end   (instr_end),
        .trap_ack    (trap_ack),
        .trace_req   (trace_req)
    );

endmodule
